// File: rtl/video_pattern_gen.sv
// video_pattern_gen: video timing generator with colour-bar, checkerboard, grey-ramp and RGB-gradient test patterns.
// Optional feature macro: PATGEN_MOVING_EN (scrolling checkerboard, frame-counted gradient blue).
module video_pattern_gen #(
   parameter int   H_ACTIVE   = 1920,
   parameter int   H_FP       = 88,
   parameter int   H_SYNC     = 44,
   parameter int   H_BP       = 148,
   parameter int   V_ACTIVE   = 1080,
   parameter int   V_FP       = 4,
   parameter int   V_SYNC     = 5,
   parameter int   V_BP       = 36,
   parameter logic HS_POL     = 1'b1,
   parameter logic VS_POL     = 1'b1,
   parameter int   CHECK_LOG2 = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] pattern_sel,
   output logic [7:0] red_o,
   output logic [7:0] green_o,
   output logic [7:0] blue_o,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic       de_out,
   output logic       frame_start_o
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int BW = H_ACTIVE / 8;
   localparam int BCW = $clog2(BW + 1);
   localparam int CW = CHECK_LOG2 + 1;
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [BCW-1:0] BAR_LAST = BCW'(BW - 1);
   localparam logic [CW-1:0] CHK_BIT = CW'(1) << CHECK_LOG2;

   logic [HW-1:0]  r_h_cnt;
   logic [VW-1:0]  r_v_cnt;
   logic [BCW-1:0] r_bar_cnt;
   logic [2:0]     r_bar_idx;
   logic [1:0]     r_pat;
   logic [7:0]     r_red, r_green, r_blue;
   logic           r_hs, r_vs, r_de, r_fs;

   logic           w_h_wrap, w_v_wrap, w_sof;
   logic [HW-1:0]  w_h_nxt;
   logic [VW-1:0]  w_v_nxt;
   logic [1:0]     w_pat;
   logic           w_de, w_hs_act, w_vs_act, w_black;
   logic [7:0]     w_x8, w_y8, w_frame8;
   logic [CW-1:0]  w_cx;
   logic [7:0]     w_red, w_green, w_blue;

   assign w_h_wrap = (r_h_cnt == H_LAST);
   assign w_v_wrap = (r_v_cnt == V_LAST);
   assign w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + HW'(1);
   assign w_v_nxt  = !w_h_wrap ? r_v_cnt : (w_v_wrap ? '0 : r_v_cnt + VW'(1));
   assign w_sof    = (r_h_cnt == '0) && (r_v_cnt == '0);
   // At the frame origin the fresh selection is used so the whole frame shares one pattern
   assign w_pat    = w_sof ? pattern_sel : r_pat;
   assign w_de     = en && (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
   assign w_hs_act = en && (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
   assign w_vs_act = en && (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
   assign w_x8     = 8'(r_h_cnt);
   assign w_y8     = 8'(r_v_cnt);
   assign w_black  = |((w_cx ^ CW'(r_v_cnt)) & CHK_BIT);

`ifdef PATGEN_MOVING_EN
   logic [7:0] r_frame_cnt;
   // Count completed frames; feeds the checkerboard scroll and the gradient blue channel
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_frame_cnt <= '0;
      else if (en && w_h_wrap && w_v_wrap)
         r_frame_cnt <= r_frame_cnt + 8'd1;
   end
   assign w_cx     = CW'(r_h_cnt) + CW'(r_frame_cnt);
   assign w_frame8 = r_frame_cnt;
`else
   assign w_cx     = CW'(r_h_cnt);
   assign w_frame8 = 8'h00;
`endif

   // Raster position; held at the origin while disabled so a re-enable starts a clean frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (!en) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else begin
         r_h_cnt <= w_h_nxt;
         r_v_cnt <= w_v_nxt;
      end
   end

   // Colour-bar index tracks h_cnt with a bar-width down-counter instead of a divider
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bar_cnt <= BAR_LAST;
         r_bar_idx <= '0;
      end else if (!en || w_h_wrap) begin
         r_bar_cnt <= BAR_LAST;
         r_bar_idx <= '0;
      end else if (r_bar_cnt == '0) begin
         r_bar_cnt <= BAR_LAST;
         r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
         r_bar_cnt <= r_bar_cnt - BCW'(1);
      end
   end

   // Latch the pattern selection once per frame at the origin
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_pat <= '0;
      else if (en && w_sof)
         r_pat <= pattern_sel;
   end

   // Pixel colour for the current position; blanking and disabled cycles are black
   always_comb begin
      w_red   = '0;
      w_green = '0;
      w_blue  = '0;
      if (w_de) begin
         case (w_pat)
            2'd0: begin
               w_red   = {8{~r_bar_idx[1]}};
               w_green = {8{~r_bar_idx[2]}};
               w_blue  = {8{~r_bar_idx[0]}};
            end
            2'd1: begin
               w_red   = {8{~w_black}};
               w_green = {8{~w_black}};
               w_blue  = {8{~w_black}};
            end
            2'd2: begin
               w_red   = w_x8;
               w_green = w_x8;
               w_blue  = w_x8;
            end
            default: begin
               w_red   = w_x8;
               w_green = w_y8;
               w_blue  = w_frame8;
            end
         endcase
      end
   end

   // Output register stage: one cycle behind the counters, all outputs mutually aligned
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
         r_hs    <= ~HS_POL;
         r_vs    <= ~VS_POL;
         r_de    <= 1'b0;
         r_fs    <= 1'b0;
      end else begin
         r_red   <= w_red;
         r_green <= w_green;
         r_blue  <= w_blue;
         r_hs    <= w_hs_act ? HS_POL : ~HS_POL;
         r_vs    <= w_vs_act ? VS_POL : ~VS_POL;
         r_de    <= w_de;
         r_fs    <= en && w_sof;
      end
   end

   assign red_o         = r_red;
   assign green_o       = r_green;
   assign blue_o        = r_blue;
   assign hsync_out     = r_hs;
   assign vsync_out     = r_vs;
   assign de_out        = r_de;
   assign frame_start_o = r_fs;
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed bench for video_pattern_gen on a 24x12 raster (16x8 active).
module tb_video_pattern_gen;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [1:0] pattern_sel = 2'd0;
   logic [7:0] red_o, green_o, blue_o;
   logic       hsync_out, vsync_out, de_out, frame_start_o;

   int n_vec = 0;
   int n_err = 0;
   int pos = -1;
   int n;
   int de_tot, hs_tot, vs_tot, fs_tot;
   logic [23:0] pix_a [288];
   logic        de_a  [288];
   logic        hs_a  [288];
   logic        vs_a  [288];
   logic        fs_a  [288];
   logic [23:0] bars  [8];
   logic [31:0] exp_b1;

   video_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CHECK_LOG2(2)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
      .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
      .frame_start_o(frame_start_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      pos = (pos + 1) % 288;
   endtask

   task automatic go(input int x, input int y);
      while (pos != y * 24 + x) step();
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rgb"}, {8'h0, red_o, green_o, blue_o}, 32'h0);
      chk({tag, "_de"}, 32'(de_out), 32'h0);
      chk({tag, "_fs"}, 32'(frame_start_o), 32'h0);
      chk({tag, "_hs"}, 32'(hsync_out), 32'h0);
      chk({tag, "_vs"}, 32'(vsync_out), 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      en = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   function automatic logic [31:0] pix();
      return {8'h0, red_o, green_o, blue_o};
   endfunction

   initial begin
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`ifdef PATGEN_MOVING_EN
      exp_b1 = 32'd1;
`else
      exp_b1 = 32'd0;
`endif
      // reset values
      step();
      step();
      chk_idle("reset");
      // timing and colour bars over one full frame
      rst = 1'b1;
      pattern_sel = 2'd0;
      en = 1'b1;
      pos = -1;
      step();
      chk("first_fs", 32'(frame_start_o), 32'h1);
      chk("first_de", 32'(de_out), 32'h1);
      for (int i = 0; i < 288; i++) begin
         if (i > 0) step();
         pix_a[pos] = {red_o, green_o, blue_o};
         de_a[pos] = de_out;
         hs_a[pos] = hsync_out;
         vs_a[pos] = vsync_out;
         fs_a[pos] = frame_start_o;
      end
      de_tot = 0; hs_tot = 0; vs_tot = 0; fs_tot = 0;
      for (int i = 0; i < 288; i++) begin
         de_tot += int'(de_a[i]);
         hs_tot += int'(hs_a[i]);
         vs_tot += int'(vs_a[i]);
         fs_tot += int'(fs_a[i]);
      end
      chk("de_total", de_tot, 128);
      chk("hs_total", hs_tot, 36);
      chk("vs_total", vs_tot, 48);
      chk("fs_total", fs_tot, 1);
      chk("fs_at_0", 32'(fs_a[0]), 32'h1);
      chk("de_15_0", 32'(de_a[15]), 32'h1);
      chk("de_16_0", 32'(de_a[16]), 32'h0);
      chk("de_0_7", 32'(de_a[7*24]), 32'h1);
      chk("de_0_8", 32'(de_a[8*24]), 32'h0);
      chk("hs_17_0", 32'(hs_a[17]), 32'h0);
      chk("hs_18_0", 32'(hs_a[18]), 32'h1);
      chk("hs_20_0", 32'(hs_a[20]), 32'h1);
      chk("hs_21_0", 32'(hs_a[21]), 32'h0);
      chk("vs_23_8", 32'(vs_a[8*24+23]), 32'h0);
      chk("vs_0_9", 32'(vs_a[9*24]), 32'h1);
      chk("vs_23_10", 32'(vs_a[10*24+23]), 32'h1);
      chk("vs_0_11", 32'(vs_a[11*24]), 32'h0);
      chk("vblank_pix", 32'(pix_a[9*24+3]), 32'h0);
      for (int x = 0; x < 24; x++)
         chk($sformatf("bar_x%0d", x), 32'(pix_a[3*24+x]), (x < 16) ? 32'(bars[x/2]) : 32'h0);
      step();
      chk("period_fs", 32'(frame_start_o), 32'h1);
      chk("period_pix", pix(), 32'hFFFFFF);
      // enable dropped mid-frame at line 5 pixel 7
      go(6, 5);
      chk("pre_drop_de", 32'(de_out), 32'h1);
      en = 1'b0;
      step();
      chk_idle("en_drop");
      step();
      chk_idle("en_hold");
      en = 1'b1;
      pos = -1;
      step();
      chk("reen_fs", 32'(frame_start_o), 32'h1);
      chk("reen_de", 32'(de_out), 32'h1);
      chk("reen_pix", pix(), 32'hFFFFFF);
      // asynchronous reset mid-active
      go(3, 0);
      chk("pre_rst_pix", pix(), 32'hFFFF00);
      #2;
      rst = 1'b0;
      #1;
      chk_idle("async_rst");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      pos = -1;
      step();
      chk("post_rst_fs", 32'(frame_start_o), 32'h1);
      n = 0;
      do begin
         step();
         n++;
      end while (!frame_start_o && n < 400);
      chk("post_rst_period", n, 288);
      // gradient, blue channel follows the frame counter only in the moving build
      do_reset();
      pattern_sel = 2'd3;
      en = 1'b1;
      pos = -1;
      step();
      go(5, 6);
      chk("grad0_r", 32'(red_o), 32'd5);
      chk("grad0_g", 32'(green_o), 32'd6);
      chk("grad0_b", 32'(blue_o), 32'd0);
      step();
      go(5, 6);
      chk("grad1_r", 32'(red_o), 32'd5);
      chk("grad1_b", 32'(blue_o), exp_b1);
      // pattern change mid-frame takes effect on the next frame
      do_reset();
      pattern_sel = 2'd1;
      en = 1'b1;
      pos = -1;
      step();
      chk("chk_0_0", pix(), 32'hFFFFFF);
      go(4, 0);
      chk("chk_4_0", pix(), 32'h000000);
      go(23, 2);
      pattern_sel = 2'd2;
      go(1, 3);
      chk("chk_1_3", pix(), 32'hFFFFFF);
      go(5, 3);
      chk("chk_5_3", pix(), 32'h000000);
      go(4, 4);
      chk("chk_4_4", pix(), 32'hFFFFFF);
      go(8, 4);
      chk("chk_8_4", pix(), 32'h000000);
      go(5, 0);
      chk("ramp_5_0", pix(), 32'h050505);
      go(13, 2);
      chk("ramp_13_2", pix(), 32'h0D0D0D);
      go(20, 2);
      chk("ramp_blank", pix(), 32'h000000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
